// File: rtl/regfile_sb_if.sv
// regfile_sb_if -- bus bundle for the scoreboarded register file.
//   master : drives read addresses, pc_in, write ports and reservations;
//            receives read data and scoreboard status.
//   slave  : the register file side (regfile_sb).
// Signals:
//   ra1..ra3 / rd1..rd3     three combinational read ports
//   pc_in                   value returned for index NREG-1
//   we0/wa0/wd0             single-cycle write port
//   we1/wa1/wd1             long-latency write port, releases a reservation
//   rsv_en/rsv_addr         reserve a destination register
//   busy1..busy3, hazard    scoreboard bits of the read addresses
//   busy_vec                full scoreboard state
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int AW     = $clog2(NREG)
);
    logic [AW-1:0]     ra1, ra2, ra3;
    logic [DATA_W-1:0] rd1, rd2, rd3;
    logic [DATA_W-1:0] pc_in;
    logic              we0;
    logic [AW-1:0]     wa0;
    logic [DATA_W-1:0] wd0;
    logic              we1;
    logic [AW-1:0]     wa1;
    logic [DATA_W-1:0] wd1;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic              busy1, busy2, busy3;
    logic              hazard;
    logic [NREG-1:0]   busy_vec;

    modport master (
        output ra1, ra2, ra3, pc_in,
        output we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr,
        input  rd1, rd2, rd3, busy1, busy2, busy3, hazard, busy_vec
    );

    modport slave (
        input  ra1, ra2, ra3, pc_in,
        input  we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr,
        output rd1, rd2, rd3, busy1, busy2, busy3, hazard, busy_vec
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb -- register file with three combinational read ports, two write
// ports and a scoreboard tracking pending long-latency writes.
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset (clears storage and scoreboard)
//   bus    regfile_sb_if.slave (read/write/reserve ports, scoreboard status)
// Index NREG-1 is the PC alias: it has no storage, always reads pc_in,
// ignores writes/reservations and is never busy.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_sb_if.slave   bus
);
    localparam int            AW     = $clog2(NREG);
    localparam int            NPHYS  = NREG - 1;
    localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);

    logic [DATA_W-1:0] r_rf [NPHYS];
    logic [NPHYS-1:0]  r_busy;

    logic              w_we0, w_we1;
    logic [AW-1:0]     w_wa0, w_wa1;
    logic [DATA_W-1:0] w_wd0, w_wd1, w_pc;
    logic              w_wr0, w_wr1;
    logic [NREG-1:0]   w_busy_vec;

    assign w_we0 = bus.we0;
    assign w_wa0 = bus.wa0;
    assign w_wd0 = bus.wd0;
    assign w_we1 = bus.we1;
    assign w_wa1 = bus.wa1;
    assign w_wd1 = bus.wd1;
    assign w_pc  = bus.pc_in;

    // Port 1 wins an address collision, so port 0 is suppressed outright.
    assign w_wr1 = w_we1 && (w_wa1 != PC_IDX);
    assign w_wr0 = w_we0 && (w_wa0 != PC_IDX) && !(w_we1 && (w_wa1 == w_wa0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NPHYS; i++) r_rf[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr0) r_rf[w_wa0] <= w_wd0;
            if (w_wr1) r_rf[w_wa1] <= w_wd1;
            // A reservation landing on the register being released keeps it
            // busy: the new producer is still outstanding.
            for (int i = 0; i < NPHYS; i++) begin
                if (bus.rsv_en && (bus.rsv_addr == AW'(i)))
                    r_busy[i] <= 1'b1;
                else if (w_we1 && (w_wa1 == AW'(i)))
                    r_busy[i] <= 1'b0;
            end
        end
    end

    function automatic logic [DATA_W-1:0] f_read(input logic [AW-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (a == PC_IDX)
            v = w_pc;
        else if ((BYPASS != 0) && w_we1 && (w_wa1 == a))
            v = w_wd1;
        else if ((BYPASS != 0) && w_we0 && (w_wa0 == a))
            v = w_wd0;
        else
            v = r_rf[a];
        return v;
    endfunction

    always_comb begin
        bus.rd1 = f_read(bus.ra1);
        bus.rd2 = f_read(bus.ra2);
        bus.rd3 = f_read(bus.ra3);
    end

    // Busy bits come straight from the registered state: no same-cycle
    // reserve/release forwarding.
    assign w_busy_vec   = {1'b0, r_busy};
    assign bus.busy_vec = w_busy_vec;
    assign bus.busy1    = w_busy_vec[bus.ra1];
    assign bus.busy2    = w_busy_vec[bus.ra2];
    assign bus.busy3    = w_busy_vec[bus.ra3];
    assign bus.hazard   = bus.busy1 | bus.busy2 | bus.busy3;
endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb (DATA_W=32, NREG=16, BYPASS=1): a table of
// directed vectors for the scoreboard/reset corner cases, then randomized
// traffic checked against an array-based reference model.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(DW), .NREG(NR)) bus ();
    regfile_sb #(.DATA_W(DW), .NREG(NR), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          rsv;
        logic [AW-1:0] rsa;
        logic [AW-1:0] ra1, ra2, ra3;
        logic [DW-1:0] e1, e2, e3;
        logic [2:0]    eb;   // {busy3, busy2, busy1}
        logic [NR-1:0] ebv;
    } vec_t;

    function automatic vec_t row(
        input logic rst,
        input logic we0, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
        input logic we1, input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
        input logic rsv, input logic [AW-1:0] rsa,
        input logic [AW-1:0] ra1, input logic [AW-1:0] ra2, input logic [AW-1:0] ra3,
        input logic [DW-1:0] e1, input logic [DW-1:0] e2, input logic [DW-1:0] e3,
        input logic [2:0] eb, input logic [NR-1:0] ebv);
        vec_t v;
        v.rst = rst; v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1; v.rsv = rsv; v.rsa = rsa;
        v.ra1 = ra1; v.ra2 = ra2; v.ra3 = ra3;
        v.e1 = e1; v.e2 = e2; v.e3 = e3; v.eb = eb; v.ebv = ebv;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic we0, input logic [AW-1:0] wa0,
                         input logic [DW-1:0] wd0, input logic we1, input logic [AW-1:0] wa1,
                         input logic [DW-1:0] wd1, input logic rsv, input logic [AW-1:0] rsa,
                         input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                         input logic [AW-1:0] ra3, input logic [DW-1:0] pc);
        rst_n = rst;
        bus.we0 = we0; bus.wa0 = wa0; bus.wd0 = wd0;
        bus.we1 = we1; bus.wa1 = wa1; bus.wd1 = wd1;
        bus.rsv_en = rsv; bus.rsv_addr = rsa;
        bus.ra1 = ra1; bus.ra2 = ra2; bus.ra3 = ra3;
        bus.pc_in = pc;
    endtask

    // Reference model state
    logic [DW-1:0] m_rf   [NR];
    logic          m_busy [NR];

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == AW'(NR - 1)) return bus.pc_in;
        if (bus.we1 && bus.wa1 == a) return bus.wd1;
        if (bus.we0 && bus.wa0 == a) return bus.wd0;
        return m_rf[a];
    endfunction

    vec_t tv [16];

    initial begin
        localparam logic [DW-1:0] PC = 32'h100;
        tv[0]  = row(1, 0,0,0,     0,0,0,     0,0,   3,15,0, 0,PC,0,       3'b000, 16'h0000);
        tv[1]  = row(1, 1,5,'hAA,  1,5,'hBB,  0,0,   5,15,0, 'hBB,PC,0,    3'b000, 16'h0000);
        tv[2]  = row(1, 0,0,0,     0,0,0,     1,7,   5,15,0, 'hBB,PC,0,    3'b000, 16'h0000);
        tv[3]  = row(1, 0,0,0,     1,7,'h55,  0,0,   0,15,7, 0,PC,'h55,    3'b100, 16'h0080);
        tv[4]  = row(1, 0,0,0,     1,4,'h11,  1,4,   4,15,7, 'h11,PC,'h55, 3'b000, 16'h0000);
        tv[5]  = row(1, 1,15,'h77, 1,15,'h88, 1,15,  4,15,5, 'h11,PC,'hBB, 3'b001, 16'h0010);
        tv[6]  = row(1, 0,0,0,     0,0,0,     1,2,   4,15,5, 'h11,PC,'hBB, 3'b001, 16'h0010);
        tv[7]  = row(1, 0,0,0,     0,0,0,     1,9,   2,15,4, 0,PC,'h11,    3'b101, 16'h0014);
        tv[8]  = row(1, 1,2,'h22,  0,0,0,     0,0,   2,9,4,  'h22,0,'h11,  3'b111, 16'h0214);
        tv[9]  = row(0, 0,0,0,     1,2,'h99,  1,3,   2,9,5,  'h99,0,'hBB,  3'b011, 16'h0214);
        tv[10] = row(1, 0,0,0,     0,0,0,     0,0,   2,4,5,  0,0,0,        3'b000, 16'h0000);
        tv[11] = row(1, 0,0,0,     1,9,'h33,  0,0,   9,15,7, 'h33,PC,0,    3'b000, 16'h0000);
        tv[12] = row(1, 0,0,0,     0,0,0,     1,3,   9,15,0, 'h33,PC,0,    3'b000, 16'h0000);
        tv[13] = row(1, 1,3,'h44,  0,0,0,     0,0,   3,15,9, 'h44,PC,'h33, 3'b001, 16'h0008);
        tv[14] = row(1, 1,6,'h61,  1,8,'h81,  0,0,   3,6,8,  'h44,'h61,'h81, 3'b001, 16'h0008);
        tv[15] = row(1, 0,0,0,     0,0,0,     0,0,   6,8,3,  'h61,'h81,'h44, 3'b100, 16'h0008);

        // One unchecked reset edge to bring storage out of X.
        drive(0, 0,0,0, 0,0,0, 0,0, 0,0,0, PC);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            drive(tv[i].rst, tv[i].we0, tv[i].wa0, tv[i].wd0, tv[i].we1, tv[i].wa1,
                  tv[i].wd1, tv[i].rsv, tv[i].rsa, tv[i].ra1, tv[i].ra2, tv[i].ra3, PC);
            @(negedge clk);
            chk($sformatf("t%0d_rd1", i), bus.rd1, tv[i].e1);
            chk($sformatf("t%0d_rd2", i), bus.rd2, tv[i].e2);
            chk($sformatf("t%0d_rd3", i), bus.rd3, tv[i].e3);
            chk($sformatf("t%0d_busy", i), {29'd0, bus.busy3, bus.busy2, bus.busy1}, {29'd0, tv[i].eb});
            chk($sformatf("t%0d_hazard", i), {31'd0, bus.hazard}, {31'd0, |tv[i].eb});
            chk($sformatf("t%0d_busy_vec", i), {16'd0, bus.busy_vec}, {16'd0, tv[i].ebv});
            @(posedge clk); #1;
        end

        // Randomized traffic. Cycle 0 is a forced reset so the model starts
        // from the same known state.
        for (int c = 0; c < 400; c++) begin
            logic r;
            logic [NR-1:0] ebv;
            r = (c == 0) ? 1'b0 : ($urandom_range(0, 24) != 0);
            drive(r, 1'($urandom), 4'($urandom), $urandom, 1'($urandom), 4'($urandom),
                  $urandom, 1'($urandom_range(0, 2) == 0), 4'($urandom),
                  4'($urandom), 4'($urandom), 4'($urandom), $urandom);
            @(negedge clk);
            if (c != 0) begin
                for (int k = 0; k < NR; k++) ebv[k] = m_busy[k];
                chk("rnd_rd1", bus.rd1, m_read(bus.ra1));
                chk("rnd_rd2", bus.rd2, m_read(bus.ra2));
                chk("rnd_rd3", bus.rd3, m_read(bus.ra3));
                chk("rnd_busy_vec", {16'd0, bus.busy_vec}, {16'd0, ebv});
                chk("rnd_hazard", {31'd0, bus.hazard},
                    {31'd0, ebv[bus.ra1] | ebv[bus.ra2] | ebv[bus.ra3]});
            end
            // Model update for this edge
            if (!r) begin
                for (int k = 0; k < NR; k++) begin m_rf[k] = '0; m_busy[k] = 1'b0; end
            end else begin
                if (bus.we0 && bus.wa0 != 4'(NR - 1)) m_rf[bus.wa0] = bus.wd0;
                if (bus.we1 && bus.wa1 != 4'(NR - 1)) m_rf[bus.wa1] = bus.wd1;
                if (bus.we1) m_busy[bus.wa1] = 1'b0;
                if (bus.rsv_en && bus.rsv_addr != 4'(NR - 1)) m_busy[bus.rsv_addr] = 1'b1;
            end
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
